// File: rtl/tx_frame_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tx_frame_decoder                                            |
// | Brief  : Rebuilds {channel, 16-bit word} from header/MSB/LSB frames. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module tx_frame_decoder #(
  parameter logic [3:0] SYNC  = 4'hA,
  parameter int         ERR_W = 8,
  parameter int         FRM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rempty,
  input  logic [7:0]       rdata,
  output logic             rinc,
  input  logic [3:0]       chan_mask,
  output logic [15:0]      data_out,
  output logic [1:0]       chan_out,
  output logic             data_avail,
  input  logic             data_accept,
  output logic [ERR_W-1:0] err_count,
  output logic [FRM_W-1:0] frame_count,
  output logic             busy
);

  localparam logic [ERR_W-1:0] c_err_max = '1;

  typedef enum logic [1:0] {
    S_HDR = 2'd0,
    S_MSB = 2'd1,
    S_LSB = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_pop;
  logic               w_hdr_ok;
  logic               w_take;
  logic [15:0]        r_data;
  logic [1:0]         r_chan;
  logic               r_avail;
  logic [ERR_W-1:0]   r_err;
  logic [FRM_W-1:0]   r_frm;

  assign w_hdr_ok = (rdata[7:4] == SYNC) && (rdata[3:2] == 2'b00);
  assign w_take   = r_avail && data_accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HDR;
    end else begin
      r_state <= w_next;
    end
  end

  // Every byte-consuming state pops as soon as the fifo has data.
  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    case (r_state)
      S_HDR: begin
        if (!rempty) begin
          w_pop = 1'b1;
          if (w_hdr_ok) begin
            w_next = S_MSB;
          end
        end
      end
      S_MSB: begin
        if (!rempty) begin
          w_pop  = 1'b1;
          w_next = S_LSB;
        end
      end
      S_LSB: begin
        if (!rempty) begin
          w_pop  = 1'b1;
          w_next = chan_mask[r_chan] ? S_OUT : S_HDR;
        end
      end
      S_OUT: begin
        if (w_take) begin
          w_next = S_HDR;
        end
      end
      default: w_next = S_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data  <= 16'h0000;
      r_chan  <= 2'b00;
      r_avail <= 1'b0;
      r_err   <= '0;
      r_frm   <= '0;
    end else begin
      if (w_pop) begin
        case (r_state)
          S_HDR: begin
            if (w_hdr_ok) begin
              r_chan <= rdata[1:0];
            end else if (r_err != c_err_max) begin
              r_err <= r_err + ERR_W'(1);
            end
          end
          S_MSB:   r_data[15:8] <= rdata;
          S_LSB: begin
            r_data[7:0] <= rdata;
            r_avail     <= chan_mask[r_chan];
          end
          default: ;
        endcase
      end
      // A word is only held in S_OUT, where no pops happen.
      if (w_take) begin
        r_avail <= 1'b0;
        r_frm   <= r_frm + FRM_W'(1);
      end
    end
  end

  assign rinc        = w_pop;
  assign data_out    = r_data;
  assign chan_out    = r_chan;
  assign data_avail  = r_avail;
  assign err_count   = r_err;
  assign frame_count = r_frm;
  assign busy        = (r_state != S_HDR);

endmodule
`default_nettype wire
